camera_controller_multirow: RTL and testbench

Parametrised next-generation exposure/readout controller for the pixel array. It accepts Init and exposure-adjust pulses and sequences Erase → Expose → row-by-row readout. Readout drives one active-low row-enable per row, generalising the fixed two-row NRE_1/NRE_2 scheme, and pulses ADC inside each row slot. It sits between the user-button front end and the pixel array/ADC and exposes the current exposure setting for display.

---
 rtl/camera_pkg.sv | 20 ++
 rtl/camera_exp_reg.sv | 45 ++++
 rtl/camera_controller_multirow.sv | 167 ++++++++++++++++
 tb/tb_camera_controller_multirow.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and default constants for the multi-row camera controller.
package camera_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExpose,
        StReadout
    } state_e;

    localparam int unsigned EXP_MIN_DEF    = 2;
    localparam int unsigned EXP_MAX_DEF    = 30;
    localparam int unsigned EXP_RESET_DEF  = 2;
    localparam int unsigned ADC_CYCLES_DEF = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/camera_exp_reg.sv
// Saturating up/down exposure setting register.
// value_next is exported so a capture starting this cycle can use the updated setting.
module camera_exp_reg #(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned EXP_MIN   = 2,
    parameter int unsigned EXP_MAX   = 30,
    parameter int unsigned EXP_RESET = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [EXP_W-1:0] value,
    output logic [EXP_W-1:0] value_next
);

    localparam logic [EXP_W-1:0] MinV   = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] MaxV   = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] ResetV = EXP_W'(EXP_RESET);

    logic [EXP_W-1:0] value_q;

    // Next setting: single-step adjust with saturation; both requests cancel.
    always_comb begin
        value_next = value_q;
        if (en && inc && !dec && (value_q < MaxV)) begin
            value_next = value_q + EXP_W'(1);
        end else if (en && dec && !inc && (value_q > MinV)) begin
            value_next = value_q - EXP_W'(1);
        end
    end

    // Setting register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= ResetV;
        end else begin
            value_q <= value_next;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/camera_controller_multirow.sv
// Exposure/readout sequencer: Erase (idle) -> Expose -> per-row readout slots.
// Optional macro AUTO_REARM_EN enables continuous capture with an Init-driven stop flag.
module camera_controller_multirow
    import camera_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 2,
    parameter int unsigned EXP_W      = 5,
    parameter int unsigned EXP_MIN    = EXP_MIN_DEF,
    parameter int unsigned EXP_MAX    = EXP_MAX_DEF,
    parameter int unsigned EXP_RESET  = EXP_RESET_DEF,
    parameter int unsigned ADC_CYCLES = ADC_CYCLES_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Init,
    input  logic                Exp_increase,
    input  logic                Exp_decrease,
    output logic [NUM_ROWS-1:0] NRE,
    output logic                ADC,
    output logic                Expose,
    output logic                Erase,
    output logic [EXP_W-1:0]    Exp_time
);

    localparam int unsigned SLOT_LEN = ADC_CYCLES + 2;
    localparam int unsigned SLOT_W   = cnt_w(SLOT_LEN);
    localparam int unsigned ROW_W    = cnt_w(NUM_ROWS);

    localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_W-1:0] AdcLast  = SLOT_W'(ADC_CYCLES);
    localparam logic [ROW_W-1:0]  RowLast  = ROW_W'(NUM_ROWS - 1);

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   exp_cnt_q, exp_cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [EXP_W-1:0]   exp_next;
    logic               exp_en;
    logic               start;
`ifdef AUTO_REARM_EN
    logic               stop_q, stop_d;
    logic               rearm_q, rearm_d;
`endif

    // Setting may only move while idle and not being consumed by a capture request.
    assign exp_en = (state_q == StIdle) && !Init;

    camera_exp_reg #(
        .EXP_W     (EXP_W),
        .EXP_MIN   (EXP_MIN),
        .EXP_MAX   (EXP_MAX),
        .EXP_RESET (EXP_RESET)
    ) u_exp_reg (
        .clk        (Clk),
        .rst        (Reset),
        .en         (exp_en),
        .inc        (Exp_increase),
        .dec        (Exp_decrease),
        .value      (Exp_time),
        .value_next (exp_next)
    );

    // State and counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            exp_cnt_q <= '0;
            row_q     <= '0;
            slot_q    <= '0;
`ifdef AUTO_REARM_EN
            stop_q    <= 1'b0;
            rearm_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            exp_cnt_q <= exp_cnt_d;
            row_q     <= row_d;
            slot_q    <= slot_d;
`ifdef AUTO_REARM_EN
            stop_q    <= stop_d;
            rearm_q   <= rearm_d;
`endif
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        row_d     = row_q;
        slot_d    = slot_q;
`ifdef AUTO_REARM_EN
        stop_d    = stop_q;
        rearm_d   = rearm_q;
        start     = Init || rearm_q;
`else
        start     = Init;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef AUTO_REARM_EN
                rearm_d = 1'b0;
`endif
                if (start) begin
                    state_d   = StExpose;
                    // exp_next equals Exp_time unless a rearm cycle adjusted it.
                    exp_cnt_d = exp_next;
                    row_d     = '0;
                    slot_d    = '0;
                end
            end
            StExpose: begin
`ifdef AUTO_REARM_EN
                if (Init) stop_d = 1'b1;
`endif
                if (exp_cnt_q <= EXP_W'(1)) begin
                    state_d = StReadout;
                    row_d   = '0;
                    slot_d  = '0;
                end else begin
                    exp_cnt_d = exp_cnt_q - EXP_W'(1);
                end
            end
            StReadout: begin
`ifdef AUTO_REARM_EN
                if (Init) stop_d = 1'b1;
`endif
                if (slot_q == SlotLast) begin
                    slot_d = '0;
                    if (row_q == RowLast) begin
                        state_d = StIdle;
                        row_d   = '0;
`ifdef AUTO_REARM_EN
                        rearm_d = !(stop_q || Init);
                        stop_d  = 1'b0;
`endif
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state, row and slot.
    always_comb begin
        NRE    = '1;
        ADC    = 1'b0;
        Expose = 1'b0;
        Erase  = 1'b0;
        unique case (state_q)
            StIdle:   Erase  = 1'b1;
            StExpose: Expose = 1'b1;
            StReadout: begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    NRE[r] = (row_q != ROW_W'(r));
                end
                ADC = (slot_q != '0) && (slot_q <= AdcLast);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_camera_controller_multirow.sv
// Directed bench for camera_controller_multirow (default parameters).
// Extra continuous-capture checks run when AUTO_REARM_EN is defined.
module tb_camera_controller_multirow;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Init = 1'b0;
    logic       Exp_increase = 1'b0;
    logic       Exp_decrease = 1'b0;
    logic [1:0] NRE;
    logic       ADC;
    logic       Expose;
    logic       Erase;
    logic [4:0] Exp_time;

    int n_vec = 0;
    int n_err = 0;

    // Outputs packed as {NRE[1:0], ADC, Expose, Erase}.
    localparam logic [4:0] O_IDLE = 5'b11_0_0_1;
    localparam logic [4:0] O_EXP  = 5'b11_0_1_0;
    localparam logic [4:0] O_R0   = 5'b10_0_0_0;
    localparam logic [4:0] O_R0A  = 5'b10_1_0_0;
    localparam logic [4:0] O_R1   = 5'b01_0_0_0;
    localparam logic [4:0] O_R1A  = 5'b01_1_0_0;

    logic [4:0] wave [11];

    camera_controller_multirow dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .NRE          (NRE),
        .ADC          (ADC),
        .Expose       (Expose),
        .Erase        (Erase),
        .Exp_time     (Exp_time)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] outs();
        return {27'd0, NRE, ADC, Expose, Erase};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        wave[0]  = O_EXP;  wave[1]  = O_EXP;
        wave[2]  = O_R0;   wave[3]  = O_R0A;  wave[4]  = O_R0A;  wave[5]  = O_R0;
        wave[6]  = O_R1;   wave[7]  = O_R1A;  wave[8]  = O_R1A;  wave[9]  = O_R1;
        wave[10] = O_IDLE;

        // Reset asserted before any clock edge: outputs must already be at reset values.
        #2 Reset = 1'b1;
        #1;
        check("reset_outs", outs(), 32'(O_IDLE));
        check("reset_exp", 32'(Exp_time), 32'd2);
        tick();
        Reset = 1'b0;
        tick();
        check("idle_outs", outs(), 32'(O_IDLE));

        // Single capture, full waveform.
        Init = 1'b1;
        tick();
        Init = 1'b0;
        check("wave_0", outs(), 32'(wave[0]));
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("wave_%0d", i), outs(), 32'(wave[i]));
        end
`ifndef AUTO_REARM_EN
        tick();
        check("stay_idle", outs(), 32'(O_IDLE));
`endif
        pulse_reset();

        // Exposure adjust and saturation.
        Exp_increase = 1'b1;
        tick();
        check("inc_step", 32'(Exp_time), 32'd3);
        repeat (39) tick();
        Exp_increase = 1'b0;
        check("inc_sat", 32'(Exp_time), 32'd30);
        Exp_decrease = 1'b1;
        tick();
        check("dec_step", 32'(Exp_time), 32'd29);
        repeat (39) tick();
        Exp_decrease = 1'b0;
        check("dec_sat", 32'(Exp_time), 32'd2);
        Exp_increase = 1'b1;
        repeat (3) tick();
        Exp_increase = 1'b0;
        check("inc_3", 32'(Exp_time), 32'd5);
        Exp_increase = 1'b1;
        Exp_decrease = 1'b1;
        repeat (3) tick();
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        check("both_hold", 32'(Exp_time), 32'd5);

        // Init together with increase: capture starts, setting stays 5.
        Init = 1'b1;
        Exp_increase = 1'b1;
        tick();
        Init = 1'b0;
        Exp_increase = 1'b0;
        check("init_inc_outs", outs(), 32'(O_EXP));
        check("init_inc_exp", 32'(Exp_time), 32'd5);
        // Decrease during EXPOSE is ignored.
        Exp_decrease = 1'b1;
        tick();
        Exp_decrease = 1'b0;
        check("dec_in_expose", 32'(Exp_time), 32'd5);
        check("expose_1", outs(), 32'(O_EXP));
        tick(); tick(); tick();
        check("expose_4", outs(), 32'(O_EXP));
        tick();
        check("ro5_slot0", outs(), 32'(O_R0));
        tick();
        check("ro5_slot1", outs(), 32'(O_R0A));
        // Init during READOUT must not restart or extend the sequence.
        Init = 1'b1;
        tick();
        Init = 1'b0;
        check("ro5_slot2", outs(), 32'(O_R0A));
        repeat (5) tick();
        check("ro5_last", outs(), 32'(O_R1));
        tick();
        check("ro5_end_idle", outs(), 32'(O_IDLE));
        repeat (3) tick();
        check("ro5_stay_idle", outs(), 32'(O_IDLE));

        // Reset between edges mid-READOUT.
        Init = 1'b1;
        tick();
        Init = 1'b0;
        repeat (6) tick();
        check("mid_ro_adc", outs(), 32'(O_R0A));
        #2 Reset = 1'b1;
        #1;
        check("async_rst_outs", outs(), 32'(O_IDLE));
        check("async_rst_exp", 32'(Exp_time), 32'd2);
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        check("post_rst_idle", outs(), 32'(O_IDLE));

`ifdef AUTO_REARM_EN
        // Continuous capture: one idle cycle, then re-expose without Init.
        Init = 1'b1;
        tick();
        Init = 1'b0;
        repeat (10) tick();
        check("rearm_idle", outs(), 32'(O_IDLE));
        tick();
        check("rearm_expose", outs(), 32'(O_EXP));
        repeat (3) tick();
        check("rearm_ro", outs(), 32'(O_R0A));
        Init = 1'b1;
        tick();
        Init = 1'b0;
        repeat (6) tick();
        check("stop_idle", outs(), 32'(O_IDLE));
        repeat (3) tick();
        check("stop_stay", outs(), 32'(O_IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
